// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV64I integer decode into a one-entry ALU issue register
// Decodes OP/OP-IMM/OP-32/OP-IMM-32/LUI/AUIPC into ALU operands and an op code.
module alu_issue #(
    parameter int DATA_LEN = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         inst_i,
    input  logic [DATA_LEN-1:0] pc_i,
    input  logic [DATA_LEN-1:0] rs1_val_i,
    input  logic [DATA_LEN-1:0] rs2_val_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_LEN-1:0] A_o,
    output logic [DATA_LEN-1:0] B_o,
    output logic [3:0]          opcode_o,
    output logic [4:0]          rd_o,
    output logic                rd_we_o,
    output logic                illegal_o
);

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_OR     = 4'd2;
    localparam logic [3:0] ALU_AND    = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_ADDW   = 4'd11;
    localparam logic [3:0] ALU_SUBW   = 4'd12;
    localparam logic [3:0] ALU_SLLW   = 4'd13;
    localparam logic [3:0] ALU_SRLW   = 4'd14;
    localparam logic [3:0] ALU_SRAW   = 4'd15;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]          major;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [DATA_LEN-1:0] imm_i;
    logic [DATA_LEN-1:0] imm_u;
    logic [DATA_LEN-1:0] shamt6;
    logic [DATA_LEN-1:0] shamt5;

    logic [DATA_LEN-1:0] dec_a;
    logic [DATA_LEN-1:0] dec_b;
    logic [3:0]          dec_op;
    logic                dec_legal;
    logic                dec_we;
    logic                accept;

    assign major  = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd     = inst_i[11:7];
    assign imm_i  = {{(DATA_LEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_u  = {{(DATA_LEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
    assign shamt6 = {{(DATA_LEN-6){1'b0}}, inst_i[25:20]};
    assign shamt5 = {{(DATA_LEN-5){1'b0}}, inst_i[24:20]};

    always_comb begin
        dec_a     = '0;
        dec_b     = '0;
        dec_op    = ALU_ADD;
        dec_legal = 1'b1;
        unique case (major)
            OPC_OP: begin
                dec_a = rs1_val_i;
                dec_b = rs2_val_i;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_op = ALU_ADD;
                    {F7_ALT,  3'b000}: dec_op = ALU_SUB;
                    {F7_BASE, 3'b001}: dec_op = ALU_SLL;
                    {F7_BASE, 3'b010}: dec_op = ALU_SLT;
                    {F7_BASE, 3'b011}: dec_op = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec_op = ALU_XOR;
                    {F7_BASE, 3'b101}: dec_op = ALU_SRL;
                    {F7_ALT,  3'b101}: dec_op = ALU_SRA;
                    {F7_BASE, 3'b110}: dec_op = ALU_OR;
                    {F7_BASE, 3'b111}: dec_op = ALU_AND;
                    default:           dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_a = rs1_val_i;
                dec_b = imm_i;
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_b = shamt6;
                        if (inst_i[31:26] == 6'b000000) dec_op = ALU_SLL;
                        else                            dec_legal = 1'b0;
                    end
                    default: begin
                        dec_b = shamt6;
                        if (inst_i[31:26] == 6'b000000)      dec_op = ALU_SRL;
                        else if (inst_i[31:26] == 6'b010000) dec_op = ALU_SRA;
                        else                                 dec_legal = 1'b0;
                    end
                endcase
            end
            OPC_OP_32: begin
                dec_a = rs1_val_i;
                dec_b = rs2_val_i;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_op = ALU_ADDW;
                    {F7_ALT,  3'b000}: dec_op = ALU_SUBW;
                    {F7_BASE, 3'b001}: dec_op = ALU_SLLW;
                    {F7_BASE, 3'b101}: dec_op = ALU_SRLW;
                    {F7_ALT,  3'b101}: dec_op = ALU_SRAW;
                    default:           dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM32: begin
                dec_a = rs1_val_i;
                dec_b = shamt5;
                case ({funct7, funct3})
                    {F7_BASE, 3'b001}: dec_op = ALU_SLLW;
                    {F7_BASE, 3'b101}: dec_op = ALU_SRLW;
                    {F7_ALT,  3'b101}: dec_op = ALU_SRAW;
                    default: begin
                        // ADDW-immediate has no funct7 field, so match funct3 alone
                        if (funct3 == 3'b000) begin
                            dec_op = ALU_ADDW;
                            dec_b  = imm_i;
                        end else begin
                            dec_legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                dec_op = ALU_COPY_B;
                dec_b  = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc_i;
                dec_b = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_a  = '0;
            dec_b  = '0;
            dec_op = ALU_ADD;
        end
    end

    assign dec_we     = dec_legal && (rd != 5'd0);
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            A_o         <= '0;
            B_o         <= '0;
            opcode_o    <= ALU_ADD;
            rd_o        <= 5'd0;
            rd_we_o     <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            A_o         <= dec_a;
            B_o         <= dec_b;
            opcode_o    <= dec_op;
            rd_o        <= rd;
            rd_we_o     <= dec_we;
            illegal_o   <= !dec_legal;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DATA_LEN, default 64, datapath width; only 64 is supported.
REQ-002 Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard held and incoming instruction.
- in_valid_i  in  1  instruction/operands valid.
- in_ready_o  out  1  block can accept.
- inst_i  in  32  RV64I instruction word.
- pc_i  in  64  instruction PC.
- rs1_val_i  in  64  register-file value of rs1.
- rs2_val_i  in  64  register-file value of rs2.
- out_valid_o  out  1  issue packet valid.
- out_ready_i  in  1  ALU stage accepts packet.
- A_o  out  64  ALU operand A.
- B_o  out  64  ALU operand B.
- opcode_o  out  4  ALU operation code.
- rd_o  out  5  destination register.
- rd_we_o  out  1  write-back enable.
- illegal_o  out  1  instruction not decodable by this block.

Function
REQ-003 ALU codes: ADD=0 SUB=1 OR=2 AND=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 COPY_B=10 ADDW=11 SUBW=12 SLLW=13 SRLW=14 SRAW=15.
REQ-004 One-entry output register; in_ready_o = !out_valid_o || out_ready_i (combinational); transfer on in_valid_i && in_ready_o.
REQ-005 Latency: accepted instruction appears on outputs the next cycle; full throughput of one per cycle while out_ready_i=1.
REQ-006 Output register holds all fields stable while out_valid_o=1 and out_ready_i=0.
REQ-007 Output consumed with no new transfer -> out_valid_o=0 next cycle; consume plus transfer same cycle -> new packet loaded, out_valid_o stays 1.
REQ-008 flush_i=1 -> out_valid_o=0 next cycle, any same-cycle transfer discarded; flush wins over accept.
REQ-009 OP (0110011): funct3 000 ADD/SUB (funct7 0000000/0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND; A=rs1, B=rs2; funct7 0100000 only legal with 000/101; any other funct7 illegal.
REQ-010 OP-IMM (0010011): same funct3 map, no SUB; B=sign-extended imm[11:0]; shifts: imm[11:6]=000000 SLL/SRL, 010000 SRA (funct3 101 only), B=zero-extended shamt[5:0]; other imm[11:6] illegal.
REQ-011 OP-32 (0111011): 000 ADDW/SUBW, 001 SLLW, 101 SRLW/SRAW; funct7 rules as REQ-009; other funct3 illegal.
REQ-012 OP-IMM-32 (0011011): 000 ADDW with sign-extended imm; 001 SLLW, 101 SRLW/SRAW with B=shamt[4:0] zero-extended; inst[25]=1 or bad funct7 illegal; other funct3 illegal.
REQ-013 LUI (0110111): COPY_B, B=sign-extended {inst[31:12],12'b0}, A=0. AUIPC (0010111): ADD, A=pc_i, B same immediate.
REQ-014 Any other major opcode or illegal pattern: illegal_o=1, opcode_o=ADD, A_o=B_o=0, rd_we_o=0; packet still issued with handshake.
REQ-015 rd_o = inst[11:7]; rd_we_o=1 for legal instructions with rd!=0, else 0.

Reset
REQ-016 rst_i=1 at a rising edge: out_valid_o=0, A_o=B_o=0, opcode_o=0, rd_o=0, rd_we_o=0, illegal_o=0; reset overrides flush and transfer.
REQ-017 Reset asserted mid-stall discards the held packet; in_ready_o=1 in the first cycle after reset release.

Verification
REQ-018 addi x1,x0,5 (0x00500093), rs1_val=0 -> next cycle out_valid=1, opcode=0, A=0, B=5, rd=1, rd_we=1.
REQ-019 sub x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> opcode=1, A=10, B=3, rd=3; mul 0x02208133 -> illegal_o=1, rd_we=0.
REQ-020 srai x5,x6,63 (0x43F35293) -> opcode=7, B=63; lui x7,0xFFFFF (0xFFFFF3B7) -> opcode=10, B=0xFFFFFFFFFFFFF000.
REQ-021 Back-pressure: out_ready_i=0 for 3 cycles with packet held and in_valid_i=1 -> in_ready_o=0, outputs unchanged; out_ready_i=1 -> next packet loaded, no loss or duplication over 20 random instructions.
REQ-022 flush_i and in_valid_i same cycle -> out_valid_o=0 next cycle; rst_i during stall -> all outputs 0 next cycle.
